// File: rtl/sar_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sar_sequencer: periodic SAR start/ready host, averaging, output FIFO  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sar_sequencer #(
    parameter int RESOLUTION = 12,
    parameter int OS_LOG2    = 2,
    parameter int PERIOD     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clear_i,
    output logic                  sar_start_o,
    input  logic                  sar_rdy_i,
    input  logic [RESOLUTION-1:0] sar_code_i,
    output logic [RESOLUTION-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o,
    output logic                  timeout_o
);

    localparam int ACC_W  = RESOLUTION + OS_LOG2;
    localparam int CNT_W  = OS_LOG2 + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int TMR_W  = $clog2(PERIOD);
    localparam int WAIT_W = $clog2(RESOLUTION + 3);

    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(PERIOD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RESOLUTION + 2);
    localparam logic [CNT_W-1:0]  AVG_N     = CNT_W'(2 ** OS_LOG2);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_PUSH} state_t;

    state_t                  state, state_nxt;
    logic [TMR_W-1:0]        timer;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    rdy_hit;
    logic                    timeout_ev;
    logic                    push_req;
    logic [RESOLUTION-1:0]   push_word;
    logic [RESOLUTION-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [FILL_W-1:0]       fill;
    logic                    pop, wr_en, overrun_ev;

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_nxt   = state;
        sar_start_o = 1'b0;
        rdy_hit     = 1'b0;
        timeout_ev  = 1'b0;
        case (state)
            S_IDLE:  if (en_i && timer == '0) state_nxt = S_START;
            S_START: begin
                sar_start_o = 1'b1;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (sar_rdy_i) begin
                    rdy_hit   = 1'b1;
                    state_nxt = (cnt_inc == AVG_N) ? S_PUSH : S_IDLE;
                end else if (wait_cnt == '0) begin
                    timeout_ev = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_PUSH:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timer is loaded on entry to START so that start pulses land exactly PERIOD apart.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            timer    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_START)
                timer <= TMR_LOAD;
            else if (timer != '0)
                timer <= timer - TMR_W'(1);
            if (state == S_START)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc       <= '0;
            cnt       <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
        end else begin
            push_req <= (state == S_PUSH);
            if (state == S_PUSH)
                push_word <= acc[ACC_W-1:OS_LOG2];
            if (state == S_PUSH || (state == S_IDLE && !en_i)) begin
                acc <= '0;
                cnt <= '0;
            end else if (rdy_hit) begin
                acc <= acc + ACC_W'(sar_code_i);
                cnt <= cnt_inc;
            end
        end
    end

    assign valid_o    = (fill != '0);
    assign pop        = valid_o && ready_i;
    assign wr_en      = push_req && (fill != FILL_FULL || pop);
    assign overrun_ev = push_req && !wr_en;
    assign data_o     = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // A fresh event in the same cycle as clear_i keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            overrun_o <= overrun_ev || (overrun_o && !clear_i);
            timeout_o <= timeout_ev || (timeout_o && !clear_i);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sar_sequencer: directed bench with SAR model and output scoreboard |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sar_sequencer;

    localparam int RESOLUTION = 12;
    localparam int OS_LOG2    = 2;
    localparam int PERIOD     = 32;
    localparam int FIFO_DEPTH = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  en_i = 1'b0;
    logic                  clear_i = 1'b0;
    logic                  sar_start_o;
    logic                  sar_rdy_i = 1'b0;
    logic [RESOLUTION-1:0] sar_code_i = '0;
    logic [RESOLUTION-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i = 1'b1;
    logic                  overrun_o;
    logic                  timeout_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [RESOLUTION-1:0] exp_q  [$];
    logic [RESOLUTION-1:0] code_q [$];
    int                    start_q[$];
    int                    rdy_q  [$];
    int  start_cnt   = 0;
    int  rdy_cnt     = 0;
    int  first_valid = -1;
    int  cd          = 0;
    bit  sar_mute    = 1'b0;

    sar_sequencer #(
        .RESOLUTION (RESOLUTION),
        .OS_LOG2    (OS_LOG2),
        .PERIOD     (PERIOD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .clear_i     (clear_i),
        .sar_start_o (sar_start_o),
        .sar_rdy_i   (sar_rdy_i),
        .sar_code_i  (sar_code_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s observed=no event expected=event within budget", tag);
    endtask

    // Behavioural SAR: ready strobe RESOLUTION+1 clocks after each start pulse.
    always @(negedge clk_i) begin
        sar_rdy_i = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                sar_rdy_i  = 1'b1;
                sar_code_i = (code_q.size() != 0) ? code_q.pop_front() : 12'h800;
                rdy_cnt++;
                rdy_q.push_back(cyc);
            end
        end
        if (sar_start_o) begin
            start_q.push_back(cyc);
            start_cnt++;
            if (!sar_mute) cd = RESOLUTION + 1;
        end
    end

    // Output scoreboard: every accepted word must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o) begin
            if (first_valid < 0) first_valid = cyc;
            if (ready_i) begin
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL sb_unexpected observed=%0h expected=none", data_o);
                end else begin
                    chk("sb_data", {20'h0, data_o}, {20'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // sel: 0 start pulse, 1 timeout_o, 2 overrun_o, 3 scoreboard empty
    task automatic wait_cond(input int sel, input int budget, input string tag, output int at);
        bit hit;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            case (sel)
                0:       hit = sar_start_o;
                1:       hit = timeout_o;
                2:       hit = overrun_o;
                default: hit = (exp_q.size() == 0);
            endcase
            if (hit) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) bound_fail(tag);
    endtask

    task automatic avg_codes(input logic [RESOLUTION-1:0] c, input bit expect_word);
        for (int i = 0; i < 4; i++) code_q.push_back(c);
        if (expect_word) exp_q.push_back(c);
    endtask

    task automatic drive_en(input logic v);
        @(posedge clk_i);
        #1 en_i = v;
    endtask

    task automatic pulse_clear();
        @(posedge clk_i);
        #1 clear_i = 1'b1;
        @(posedge clk_i);
        #1 clear_i = 1'b0;
    endtask

    initial begin
        int t, t2, tm, snap;

        // Reset state
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_start", {31'h0, sar_start_o}, 0);
        chk("rst_valid", {31'h0, valid_o}, 0);
        chk("rst_data", {20'h0, data_o}, 0);
        chk("rst_overrun", {31'h0, overrun_o}, 0);
        chk("rst_timeout", {31'h0, timeout_o}, 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // 1: constant code, start spacing and output latency
        start_q.delete();
        rdy_q.delete();
        first_valid = -1;
        avg_codes(12'h800, 1'b1);
        drive_en(1'b1);
        wait_cond(3, 300, "t1_word", t);
        drive_en(1'b0);
        if (start_q.size() >= 4 && rdy_q.size() >= 4) begin
            chk("t1_gap0", start_q[1] - start_q[0], 32);
            chk("t1_gap1", start_q[2] - start_q[1], 32);
            chk("t1_gap2", start_q[3] - start_q[2], 32);
            chk("t1_rdy_lat", rdy_q[0] - start_q[0], 13);
            chk("t1_valid_lat", first_valid - rdy_q[3], 3);
        end else begin
            bound_fail("t1_history");
        end

        // 2: truncating average and full-scale
        code_q.push_back(12'h001);
        code_q.push_back(12'h002);
        code_q.push_back(12'h003);
        code_q.push_back(12'h004);
        exp_q.push_back(12'h002);
        avg_codes(12'hFFF, 1'b1);
        drive_en(1'b1);
        wait_cond(3, 400, "t2_words", t);
        drive_en(1'b0);

        // 3: back-pressure, overrun, in-order drain, clear
        ready_i = 1'b0;
        avg_codes(12'h111, 1'b1);
        avg_codes(12'h222, 1'b1);
        avg_codes(12'h333, 1'b1);
        avg_codes(12'h444, 1'b1);
        avg_codes(12'h555, 1'b0);
        drive_en(1'b1);
        wait_cond(2, 800, "t3_overrun", t);
        drive_en(1'b0);
        @(negedge clk_i);
        chk("t3_overrun", {31'h0, overrun_o}, 1);
        chk("t3_valid_held", {31'h0, valid_o}, 1);
        chk("t3_head", {20'h0, data_o}, 32'h111);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        wait_cond(3, 20, "t3_drain", t);
        @(negedge clk_i);
        chk("t3_drained", {31'h0, valid_o}, 0);
        chk("t3_overrun_kept", {31'h0, overrun_o}, 1);
        pulse_clear();
        @(negedge clk_i);
        chk("t3_overrun_clr", {31'h0, overrun_o}, 0);

        // 4: SAR never answers
        sar_mute = 1'b1;
        drive_en(1'b1);
        wait_cond(0, 40, "t4_start", t);
        wait_cond(1, 40, "t4_timeout", tm);
        chk("t4_timeout_delay", tm - t, 16);
        wait_cond(0, 40, "t4_restart", t2);
        chk("t4_restart_gap", t2 - t, 32);
        drive_en(1'b0);
        repeat (20) @(negedge clk_i);
        chk("t4_no_write", {31'h0, valid_o}, 0);
        pulse_clear();
        @(negedge clk_i);
        chk("t4_timeout_clr", {31'h0, timeout_o}, 0);
        sar_mute = 1'b0;

        // 5: disable mid-average, partial sum discarded
        start_cnt = 0;
        rdy_cnt   = 0;
        for (int i = 0; i < 3; i++) code_q.push_back(12'h700);
        drive_en(1'b1);
        for (int i = 0; i < 3; i++) wait_cond(0, 40, "t5_start", t);
        drive_en(1'b0);
        repeat (100) @(negedge clk_i);
        chk("t5_inflight_done", rdy_cnt, 3);
        chk("t5_no_more_starts", start_cnt, 3);
        chk("t5_no_word", {31'h0, valid_o}, 0);
        avg_codes(12'h100, 1'b1);
        drive_en(1'b1);
        wait_cond(3, 200, "t5_word", t);
        drive_en(1'b0);

        // 6: reset mid-WAIT with two words queued
        ready_i = 1'b0;
        avg_codes(12'h0AA, 1'b0);
        avg_codes(12'h0BB, 1'b0);
        code_q.push_back(12'h0CC);
        drive_en(1'b1);
        for (int i = 0; i < 9; i++) wait_cond(0, 40, "t6_start", t);
        repeat (5) @(negedge clk_i);
        chk("t6_head", {20'h0, data_o}, 32'h0AA);
        chk("t6_valid", {31'h0, valid_o}, 1);
        snap = rdy_cnt;
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        en_i = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t6_valid_rst", {31'h0, valid_o}, 0);
        chk("t6_start_rst", {31'h0, sar_start_o}, 0);
        chk("t6_data_rst", {20'h0, data_o}, 0);
        chk("t6_overrun_rst", {31'h0, overrun_o}, 0);
        chk("t6_timeout_rst", {31'h0, timeout_o}, 0);
        ready_i = 1'b1;
        repeat (30) @(negedge clk_i);
        chk("t6_late_rdy_seen", rdy_cnt - snap, 1);
        chk("t6_no_spurious", {31'h0, valid_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
